op_fetch: RTL and testbench
===========================

Name: op_fetch

Overview:
- Fetch sequencer directly downstream of the opmem control stage.
- Owns the program counter, drives the opmem address and output-register enable, and tracks the fixed RAM read latency.
- Buffers returned ops in a small FIFO and hands them to the execute stage over a valid/ready handshake.
- Supports start, stop/drain and jump (flush) requests.

Parameters:
- ADDR_W, 4, opmem address width; PC wraps modulo 2^ADDR_W.
- OP_W, 8, op width.
- RD_LAT, 2, cycles from mem_addr issue to valid op_in (BSRAM with output register).
- FIFO_D, 3, output FIFO depth; must be >= RD_LAT+1 for full throughput.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous reset, active-low.
- start  in  1  pulse; begin fetching at start_addr (honoured in IDLE only).
- start_addr  in  ADDR_W  first fetch address.
- stop  in  1  pulse; stop issuing and drain (honoured in RUN only).
- jump_en  in  1  pulse; redirect fetch (honoured in RUN only).
- jump_addr  in  ADDR_W  redirect target.
- mem_write  in  1  opmem write in progress; inhibits issue that cycle.
- mem_addr  out  ADDR_W  opmem read address.
- mem_oce  out  1  opmem output-register enable.
- op_in  in  OP_W  op data from opmem.
- op_out  out  OP_W  head-of-FIFO op.
- op_pc  out  ADDR_W  address op_out was fetched from.
- op_valid  out  1  FIFO non-empty.
- op_ready  in  1  execute stage accepts op_out.
- busy  out  1  state != IDLE or ops in flight.

Behaviour:
- Reset (rst low, async):
  - state=IDLE; pc=0; mem_addr=0; mem_oce=0; FIFO and in-flight pipe cleared; epoch=0.
  - op_valid=0, op_out=0, op_pc=0, busy=0.
  - Reset mid-operation discards everything immediately.
- mem_oce: 0 in reset, 1 on every cycle after rst deasserts. The RAM pipeline never stalls, so latency is always exactly RD_LAT.
- States:
  - IDLE: on start, pc<=start_addr and go to RUN.
  - RUN: on stop, go to DRAIN; on jump_en, stay in RUN and flush (below).
  - DRAIN: no issue; when in-flight count reaches 0, go to IDLE. FIFO contents remain poppable in IDLE.
- Issue rule: in RUN, issue when !mem_write && (fifo_count + inflight_count) < FIFO_D.
  - Issue drives mem_addr=pc, pushes {valid, epoch, pc} into an RD_LAT-deep tag pipe, and sets pc<=pc+1 (2^ADDR_W-1 wraps to 0).
- Return: when the tag pipe tail is valid and its epoch equals the current epoch, push {op_in, tag pc} into the FIFO. Stale-epoch returns are dropped.
  - The credit rule guarantees the FIFO never overflows. Assert no push while full.
- Pop: on op_valid && op_ready. Push and pop in the same cycle keep fifo_count unchanged.
- Jump (RUN):
  - Clear FIFO, toggle epoch, pc<=jump_addr, no issue that cycle.
  - First issue of jump_addr occurs the next cycle, so the first post-jump op is valid RD_LAT+1 cycles after jump_en.
  - Jump has priority over a simultaneous pop and push: both are discarded.
  - jump_en in IDLE or DRAIN is ignored.
- start and stop in the same cycle: only the one legal in the current state takes effect.
- Throughput: one op per cycle sustained while op_ready=1 and mem_write=0.

Optional Feature:
- OP_FETCH_HALT_EN defined:
  - When an op equal to OP_HALT (8'hFF) is pushed into the FIFO with the current epoch, the FSM moves RUN->DRAIN as if stop were pulsed.
  - Younger in-flight ops still land in the FIFO.
- Undefined: 8'hFF is an ordinary op; only stop ends fetching.

Decomposition:
- Shared include op_defs.vh:
  - OP_W and ADDR_W defaults.
  - OP_HALT=8'hFF.
  - FSM encodings: S_IDLE=2'd0, S_RUN=2'd1, S_DRAIN=2'd2.
- One sub-module: op_fetch_fifo.
  - Synchronous FIFO, FIFO_D entries of {OP_W+ADDR_W}, with count output and a synchronous clear.

Test Plan:
- Reset then start, start_addr=4'h0, op_ready=1, RAM preloaded op[i]=i+8'h10 -> first op_valid at cycle 3 after start with op_out=8'h10, op_pc=0; then 8'h11, 8'h12... one per cycle.
- op_ready held 0 for 10 cycles -> exactly 3 ops buffered, mem_addr frozen, no overflow; release -> ops 0,1,2,3 in order with no gaps or duplicates.
- jump_en with jump_addr=4'hA while ops 2..4 are buffered or in flight -> FIFO cleared, stale ops dropped, next valid op has op_pc=4'hA, 3 cycles after jump.
- start_addr=4'hE, run 4 ops -> op_pc sequence E,F,0,1.
- mem_write high 2 cycles mid-run -> no issue on those cycles, op order preserved; stop -> busy falls after in-flight ops drain, state IDLE.
- OP_FETCH_HALT_EN: 8'hFF at address 5 -> fetch enters DRAIN, final ops delivered are 5,6,7, then busy=0; without the macro, fetch continues past 5.

Source files
------------

// File: rtl/op_fetch_pkg.sv
// Shared types and constants for the op fetch sequencer.
package op_fetch_pkg;

    localparam int unsigned ADDR_W     = 4;
    localparam int unsigned OP_W       = 8;
    localparam int unsigned DEF_RD_LAT = 2;
    localparam int unsigned DEF_FIFO_D = 3;

    localparam logic [OP_W-1:0] OP_HALT = OP_W'(8'hFF);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    // One buffered op and the address it came from.
    typedef struct packed {
        logic [OP_W-1:0]   op;
        logic [ADDR_W-1:0] pc;
    } fifo_entry_t;

    // Tag travelling alongside an outstanding RAM read.
    typedef struct packed {
        logic              vld;
        logic              epoch;
        logic [ADDR_W-1:0] pc;
    } tag_t;

endpackage

// File: rtl/op_fetch_fifo.sv
// Shift-register FIFO: entry 0 is always the head, so the head output is a flop.
module op_fetch_fifo
    import op_fetch_pkg::*;
#(
    parameter int unsigned DEPTH = DEF_FIFO_D,
    parameter int unsigned CNT_W = $clog2(DEPTH + 1)
)
(
    input  logic              clk,
    input  logic              rst,
    input  logic              i_clr,
    input  logic              i_push,
    input  fifo_entry_t       i_wdata,
    input  logic              i_pop,
    output fifo_entry_t       o_head,
    output logic              o_valid,
    output logic [CNT_W-1:0]  o_count
);

    fifo_entry_t      r_mem [DEPTH];
    logic [CNT_W-1:0] r_count;
    logic             r_valid;

    fifo_entry_t      w_next [DEPTH];
    logic [CNT_W-1:0] w_widx;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_pop;
    logic             w_full;

    assign w_pop   = i_pop && (r_count != '0);
    assign w_full  = (r_count == CNT_W'(DEPTH));
    assign o_head  = r_mem[0];
    assign o_valid = r_valid;
    assign o_count = r_count;

    // Next storage image: shift on pop, then write the new entry behind the last live one.
    always_comb begin
        w_widx = w_pop ? (r_count - CNT_W'(1)) : r_count;
        for (int i = 0; i < int'(DEPTH); i++) begin
            w_next[i] = r_mem[i];
        end
        if (w_pop) begin
            for (int i = 0; i < int'(DEPTH) - 1; i++) begin
                w_next[i] = r_mem[i + 1];
            end
        end
        if (i_push) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                if (CNT_W'(i) == w_widx) begin
                    w_next[i] = i_wdata;
                end
            end
        end
    end

    // Occupancy after this cycle's push/pop; clear wins.
    always_comb begin
        w_cnt_nxt = r_count;
        if (i_clr) begin
            w_cnt_nxt = '0;
        end else if (i_push && !w_pop) begin
            w_cnt_nxt = r_count + CNT_W'(1);
        end else if (!i_push && w_pop) begin
            w_cnt_nxt = r_count - CNT_W'(1);
        end
    end

    // Storage and occupancy registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_mem[i] <= '0;
            end
            r_count <= '0;
            r_valid <= 1'b0;
        end else begin
            if (!i_clr) begin
                for (int i = 0; i < int'(DEPTH); i++) begin
                    r_mem[i] <= w_next[i];
                end
            end
            r_count <= w_cnt_nxt;
            r_valid <= (w_cnt_nxt != '0);
        end
    end

    // Upstream credit accounting must never push into a full FIFO.
    a_no_overflow: assert property (@(posedge clk) disable iff (!rst)
        !(i_push && w_full && !i_clr));

endmodule

// File: rtl/op_fetch.sv
// Fetch sequencer: owns the PC, issues opmem reads, tracks read latency with
// an epoch-tagged pipe, and buffers returned ops for the execute stage.
// Optional: OP_FETCH_HALT_EN makes an OP_HALT op end fetching like a stop.
module op_fetch
    import op_fetch_pkg::*;
#(
    parameter int unsigned RD_LAT = DEF_RD_LAT,
    parameter int unsigned FIFO_D = DEF_FIFO_D
)
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic              stop,
    input  logic              jump_en,
    input  logic [ADDR_W-1:0] jump_addr,
    input  logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_oce,
    input  logic [OP_W-1:0]   op_in,
    output logic [OP_W-1:0]   op_out,
    output logic [ADDR_W-1:0] op_pc,
    output logic              op_valid,
    input  logic              op_ready,
    output logic              busy
);

    localparam int unsigned CNT_W = $clog2(FIFO_D + 1);
    localparam int unsigned SUM_W = $clog2(FIFO_D + RD_LAT + 1);

    state_t            r_state;
    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] r_mem_addr;
    logic              r_oce;
    logic              r_epoch;
    logic              r_busy;
    tag_t              r_tag [RD_LAT];

    state_t            w_state_nxt;
    tag_t              w_tag_nxt [RD_LAT];
    tag_t              w_tail;
    logic [SUM_W-1:0]  w_inflight;
    logic [SUM_W-1:0]  w_inflight_nxt;
    logic [SUM_W-1:0]  w_credit;
    logic [CNT_W-1:0]  w_fifo_cnt;
    fifo_entry_t       w_head;
    fifo_entry_t       w_wdata;
    logic              w_fifo_valid;
    logic              w_run;
    logic              w_stop;
    logic              w_jump;
    logic              w_pop;
    logic              w_push;
    logic              w_issue;
    logic              w_halt;

    assign w_tail = r_tag[RD_LAT-1];
    assign w_run  = (r_state == S_RUN);
    assign w_stop = w_run && stop;
    assign w_jump = w_run && jump_en && !stop;
    assign w_pop  = w_fifo_valid && op_ready;

    // A returning op is kept only if it belongs to the current epoch and no flush is happening.
    assign w_push        = w_tail.vld && (w_tail.epoch == r_epoch) && !w_jump;
    assign w_wdata.op    = op_in;
    assign w_wdata.pc    = w_tail.pc;

`ifdef OP_FETCH_HALT_EN
    assign w_halt = w_run && w_push && (op_in == OP_HALT);
`else
    assign w_halt = 1'b0;
`endif

    // Credit check counts buffered plus outstanding ops; the slot freed by this cycle's pop is reusable.
    always_comb begin
        w_inflight = '0;
        for (int i = 0; i < int'(RD_LAT); i++) begin
            w_inflight = w_inflight + SUM_W'(r_tag[i].vld);
        end
        w_credit = SUM_W'(w_fifo_cnt) + w_inflight - SUM_W'(w_pop);
        w_issue  = w_run && !w_jump && !w_stop && !mem_write && (w_credit < SUM_W'(FIFO_D));
    end

    // Tag pipe advance and resulting outstanding count.
    always_comb begin
        w_tag_nxt[0].vld   = w_issue;
        w_tag_nxt[0].epoch = r_epoch;
        w_tag_nxt[0].pc    = r_pc;
        for (int i = 1; i < int'(RD_LAT); i++) begin
            w_tag_nxt[i] = r_tag[i - 1];
        end
        w_inflight_nxt = '0;
        for (int i = 0; i < int'(RD_LAT); i++) begin
            w_inflight_nxt = w_inflight_nxt + SUM_W'(w_tag_nxt[i].vld);
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (w_stop || w_halt) begin
                    w_state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (w_inflight == '0) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // PC, epoch, RAM address/enable, tag pipe and busy.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pc       <= '0;
            r_mem_addr <= '0;
            r_oce      <= 1'b0;
            r_epoch    <= 1'b0;
            r_busy     <= 1'b0;
            for (int i = 0; i < int'(RD_LAT); i++) begin
                r_tag[i] <= '0;
            end
        end else begin
            r_oce  <= 1'b1;
            r_busy <= (w_state_nxt != S_IDLE) || (w_inflight_nxt != '0);
            for (int i = 0; i < int'(RD_LAT); i++) begin
                r_tag[i] <= w_tag_nxt[i];
            end
            if ((r_state == S_IDLE) && start) begin
                r_pc <= start_addr;
            end else if (w_jump) begin
                r_pc    <= jump_addr;
                r_epoch <= ~r_epoch;
            end else if (w_issue) begin
                r_pc       <= r_pc + ADDR_W'(1);
                r_mem_addr <= r_pc;
            end
        end
    end

    // Output op buffer; a jump flushes it and discards any same-cycle pop.
    op_fetch_fifo #(
        .DEPTH (FIFO_D),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_clr   (w_jump),
        .i_push  (w_push),
        .i_wdata (w_wdata),
        .i_pop   (w_pop && !w_jump),
        .o_head  (w_head),
        .o_valid (w_fifo_valid),
        .o_count (w_fifo_cnt)
    );

    assign mem_addr = r_mem_addr;
    assign mem_oce  = r_oce;
    assign op_out   = w_head.op;
    assign op_pc    = w_head.pc;
    assign op_valid = w_fifo_valid;
    assign busy     = r_busy;

endmodule

// File: tb/tb_op_fetch.sv
// Directed bench for op_fetch with a one-cycle registered RAM model behind mem_addr.
module tb_op_fetch;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [3:0] start_addr;
    logic       stop;
    logic       jump_en;
    logic [3:0] jump_addr;
    logic       mem_write;
    logic [3:0] mem_addr;
    logic       mem_oce;
    logic [7:0] op_in;
    logic [7:0] op_out;
    logic [3:0] op_pc;
    logic       op_valid;
    logic       op_ready;
    logic       busy;

    logic [7:0] ram [16];
    logic [7:0] r_q = '0;
    logic [3:0] q_pc [$];

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    op_fetch dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .start_addr (start_addr),
        .stop       (stop),
        .jump_en    (jump_en),
        .jump_addr  (jump_addr),
        .mem_write  (mem_write),
        .mem_addr   (mem_addr),
        .mem_oce    (mem_oce),
        .op_in      (op_in),
        .op_out     (op_out),
        .op_pc      (op_pc),
        .op_valid   (op_valid),
        .op_ready   (op_ready),
        .busy       (busy)
    );

    // opmem read path: address registered in the DUT, data registered here.
    always @(posedge clk) begin
        if (mem_oce) r_q <= ram[mem_addr];
    end
    assign op_in = r_q;

    // Record every op the execute stage actually takes (a jump cycle discards the pop).
    always @(negedge clk) begin
        if (rst && op_valid && op_ready && !jump_en) q_pc.push_back(op_pc);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_op(input string tag, input logic [3:0] pc, input logic [7:0] op);
        check({tag, "_valid"}, 32'(op_valid), 32'd1);
        check({tag, "_pc"}, 32'(op_pc), 32'(pc));
        check({tag, "_op"}, 32'(op_out), 32'(op));
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n = 0;
        while (busy && n < budget) begin
            tick();
            n++;
        end
        check(tag, 32'(busy), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b0; start = 1'b0; start_addr = '0; stop = 1'b0;
        jump_en = 1'b0; jump_addr = '0; mem_write = 1'b0; op_ready = 1'b1;
        for (int i = 0; i < 16; i++) ram[i] = 8'(i + 16);

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        check("rst_oce", 32'(mem_oce), 32'd0);
        check("rst_valid", 32'(op_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_addr", 32'(mem_addr), 32'd0);
        check("rst_out", 32'(op_out), 32'd0);
        check("rst_pc", 32'(op_pc), 32'd0);
        #2 rst = 1'b1;
        tick();
        check("oce_on", 32'(mem_oce), 32'd1);

        // Start at 0: first op three cycles after start, then one per cycle; stop drains
        q_pc.delete();
        start_addr = 4'h0; start = 1'b1; tick(); start = 1'b0;
        check("t1_busy", 32'(busy), 32'd1);
        check("t1_lat0", 32'(op_valid), 32'd0);
        tick(); check("t1_lat1", 32'(op_valid), 32'd0);
        tick(); check("t1_lat2", 32'(op_valid), 32'd0);
        tick(); check_op("t1_op0", 4'h0, 8'h10);
        tick(); check_op("t1_op1", 4'h1, 8'h11);
        tick(); check_op("t1_op2", 4'h2, 8'h12);
        stop = 1'b1; tick(); stop = 1'b0;
        check("t1_addr_frozen", 32'(mem_addr), 32'd4);
        wait_idle("t1_drain", 20);
        check("t1_empty", 32'(op_valid), 32'd0);
        check("t1_count", 32'(q_pc.size()), 32'd5);
        for (int i = 0; i < q_pc.size() && i < 5; i++) check("t1_order", 32'(q_pc[i]), 32'(i));

        // Consumer stalled: exactly three ops buffered, address frozen, then gap-free release
        q_pc.delete();
        op_ready = 1'b0;
        start_addr = 4'h0; start = 1'b1; tick(); start = 1'b0;
        repeat (6) tick();
        check("t2_addr_mid", 32'(mem_addr), 32'd2);
        repeat (3) tick();
        check_op("t2_head", 4'h0, 8'h10);
        check("t2_addr", 32'(mem_addr), 32'd2);
        check("t2_nopop", 32'(q_pc.size()), 32'd0);
        op_ready = 1'b1;
        tick(); check_op("t2_r1", 4'h1, 8'h11);
        tick(); check_op("t2_r2", 4'h2, 8'h12);
        tick(); check_op("t2_r3", 4'h3, 8'h13);
        tick(); check_op("t2_r4", 4'h4, 8'h14);

        // Jump to A: flush, stale returns dropped, first new op RD_LAT+1 cycles later
        jump_en = 1'b1; jump_addr = 4'hA; tick(); jump_en = 1'b0;
        check("j_flush0", 32'(op_valid), 32'd0);
        tick(); check("j_flush1", 32'(op_valid), 32'd0);
        tick(); check("j_flush2", 32'(op_valid), 32'd0);
        tick(); check_op("j_first", 4'hA, 8'h1A);
        tick(); check_op("j_next", 4'hB, 8'h1B);
        check("j_popcount", 32'(q_pc.size()), 32'd5);
        if (q_pc.size() == 5) begin
            check("j_pop3", 32'(q_pc[3]), 32'd3);
            check("j_popA", 32'(q_pc[4]), 32'hA);
        end
        stop = 1'b1; tick(); stop = 1'b0;
        wait_idle("j_drain", 20);

        // Wrap E,F,0,1 then mem_write inhibits issue for two cycles, then stop
        start_addr = 4'hE; start = 1'b1; tick(); start = 1'b0;
        tick(); tick();
        tick(); check_op("w_e", 4'hE, 8'h1E);
        tick(); check_op("w_f", 4'hF, 8'h1F);
        tick(); check_op("w_0", 4'h0, 8'h10);
        tick(); check_op("w_1", 4'h1, 8'h11);
        mem_write = 1'b1;
        tick(); check_op("mw_2", 4'h2, 8'h12); check("mw_addr_a", 32'(mem_addr), 32'd3);
        tick(); check_op("mw_3", 4'h3, 8'h13); check("mw_addr_b", 32'(mem_addr), 32'd3);
        mem_write = 1'b0;
        tick(); check("mw_gap0", 32'(op_valid), 32'd0); check("mw_addr_c", 32'(mem_addr), 32'd4);
        tick(); check("mw_gap1", 32'(op_valid), 32'd0);
        tick(); check_op("mw_4", 4'h4, 8'h14);
        tick(); check_op("mw_5", 4'h5, 8'h15);
        stop = 1'b1; tick(); stop = 1'b0;
        check_op("st_6", 4'h6, 8'h16);
        tick(); check_op("st_7", 4'h7, 8'h17); check("st_busy", 32'(busy), 32'd1);
        tick(); check("st_idle", 32'(busy), 32'd0); check("st_empty", 32'(op_valid), 32'd0);
        check("st_addr", 32'(mem_addr), 32'd7);

        // Jump while idle is ignored
        jump_en = 1'b1; jump_addr = 4'h3; tick(); jump_en = 1'b0;
        check("ij_busy", 32'(busy), 32'd0);
        check("ij_addr", 32'(mem_addr), 32'd7);

        // start+stop together in IDLE: start wins; OP_HALT at address 5
        ram[5] = 8'hFF;
        start_addr = 4'h3; start = 1'b1; stop = 1'b1; tick(); start = 1'b0; stop = 1'b0;
        check("ss_busy", 32'(busy), 32'd1);
        tick(); tick();
        tick(); check_op("h_3", 4'h3, 8'h13);
        tick(); check_op("h_4", 4'h4, 8'h14);
        tick(); check_op("h_5", 4'h5, 8'hFF);
        tick(); check_op("h_6", 4'h6, 8'h16);
        tick(); check_op("h_7", 4'h7, 8'h17);
        tick();
`ifdef OP_FETCH_HALT_EN
        check("h_end_valid", 32'(op_valid), 32'd0);
        check("h_end_busy", 32'(busy), 32'd0);
`else
        check_op("h_8", 4'h8, 8'h18);
        check("h_cont_busy", 32'(busy), 32'd1);
        stop = 1'b1; tick(); stop = 1'b0;
        wait_idle("h_drain", 20);
`endif
        ram[5] = 8'h15;

        // Reset mid-operation discards everything at once
        start_addr = 4'h0; start = 1'b1; tick(); start = 1'b0;
        tick(); tick(); tick();
        check("mr_pre_valid", 32'(op_valid), 32'd1);
        #2 rst = 1'b0;
        #1;
        check("mr_valid", 32'(op_valid), 32'd0);
        check("mr_busy", 32'(busy), 32'd0);
        check("mr_oce", 32'(mem_oce), 32'd0);
        check("mr_addr", 32'(mem_addr), 32'd0);
        tick();
        #2 rst = 1'b1;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
